// File: rtl/wb_retire_checker_if.sv
// CPU writeback / pipeline-status port and expected-table load port of wb_retire_checker.
interface wb_retire_checker_if #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_CHECKS = 16
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_CHECKS);

  logic            halt;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            flush;
  logic            exp_we;
  logic [CW-1:0]   exp_idx;
  logic            exp_valid;
  logic [RW-1:0]   exp_rd;
  logic [XLEN-1:0] exp_data;

  modport master (
    output halt, wb_we, wb_rd, wb_data, stall, flush,
    output exp_we, exp_idx, exp_valid, exp_rd, exp_data
  );

  modport slave (
    input halt, wb_we, wb_rd, wb_data, stall, flush,
    input exp_we, exp_idx, exp_valid, exp_rd, exp_data
  );
endinterface

// File: rtl/wb_retire_checker.sv
// Writeback checker: shadows the register file during RUN, then scans an expected-value table.
// Optional first-mismatch capture outputs are built when WB_CHECKER_FIRST_FAIL_EN is defined.
module wb_retire_checker #(
  parameter int  XLEN       = 32,
  parameter int  NUM_REGS   = 32,
  parameter int  NUM_CHECKS = 16,
  parameter int  CNT_W      = 32,
  parameter int  TIMEOUT    = 1000,
  localparam int RW         = $clog2(NUM_REGS),
  localparam int CW         = $clog2(NUM_CHECKS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  wb_retire_checker_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CW:0]         fail_count,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    retire_count,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
`ifdef WB_CHECKER_FIRST_FAIL_EN
  ,
  output logic                first_fail_valid,
  output logic [RW-1:0]       first_fail_rd,
  output logic [XLEN-1:0]     first_fail_actual
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t          r_state, w_next_state;
  logic [XLEN-1:0] r_shadow   [NUM_REGS];
  logic [RW-1:0]   r_exp_rd   [NUM_CHECKS];
  logic [XLEN-1:0] r_exp_data [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] r_exp_valid;
  logic [CW-1:0]   r_idx;
  logic            r_timeout;
  logic [CW:0]     r_fail_count;
  logic [CNT_W-1:0] r_cycle_count, r_retire_count, r_stall_count, r_flush_count;

  logic            w_idle_or_done, w_hit_timeout, w_last_idx, w_mismatch, w_wb_hit;
  logic [XLEN-1:0] w_actual;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  // The TIMEOUT-th RUN cycle is the one that sees TIMEOUT-1 already counted.
  assign w_hit_timeout  = (r_cycle_count == CNT_W'(TIMEOUT - 1));
  assign w_last_idx     = (r_idx == CW'(NUM_CHECKS - 1));
  assign w_actual       = r_shadow[r_exp_rd[r_idx]];
  assign w_mismatch     = r_exp_valid[r_idx] && (w_actual != r_exp_data[r_idx]);
  assign w_wb_hit       = bus.wb_we && (bus.wb_rd != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_RUN;
      S_RUN:          if (w_hit_timeout || bus.halt) w_next_state = S_CHECK;
      S_CHECK:        if (w_last_idx) w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shadow file and table valid bits are architecturally reset; table payload is not.
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      r_exp_valid    <= '0;
      r_idx          <= '0;
      r_timeout      <= 1'b0;
      r_fail_count   <= '0;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
      r_stall_count  <= '0;
      r_flush_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
            r_idx          <= '0;
            r_timeout      <= 1'b0;
            r_fail_count   <= '0;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
            r_stall_count  <= '0;
            r_flush_count  <= '0;
          end
        end
        S_RUN: begin
          r_cycle_count <= sat_inc(r_cycle_count, 1'b1);
          r_stall_count <= sat_inc(r_stall_count, bus.stall);
          r_flush_count <= sat_inc(r_flush_count, bus.flush);
          if (w_wb_hit) begin
            r_shadow[bus.wb_rd] <= bus.wb_data;
            r_retire_count      <= sat_inc(r_retire_count, 1'b1);
          end
          if (w_hit_timeout) r_timeout <= 1'b1;
        end
        S_CHECK: begin
          if (w_mismatch) r_fail_count <= r_fail_count + (CW+1)'(1);
          r_idx <= w_last_idx ? '0 : r_idx + CW'(1);
        end
        default: ;
      endcase
      if (w_idle_or_done && bus.exp_we) r_exp_valid[bus.exp_idx] <= bus.exp_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle_or_done && bus.exp_we) begin
      r_exp_rd[bus.exp_idx]   <= bus.exp_rd;
      r_exp_data[bus.exp_idx] <= bus.exp_data;
    end
  end

`ifdef WB_CHECKER_FIRST_FAIL_EN
  logic            r_ff_valid;
  logic [RW-1:0]   r_ff_rd;
  logic [XLEN-1:0] r_ff_actual;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ff_valid  <= 1'b0;
      r_ff_rd     <= '0;
      r_ff_actual <= '0;
    end else if (w_idle_or_done && start) begin
      r_ff_valid  <= 1'b0;
      r_ff_rd     <= '0;
      r_ff_actual <= '0;
    end else if ((r_state == S_CHECK) && w_mismatch && !r_ff_valid) begin
      r_ff_valid  <= 1'b1;
      r_ff_rd     <= r_exp_rd[r_idx];
      r_ff_actual <= w_actual;
    end
  end

  assign first_fail_valid  = r_ff_valid;
  assign first_fail_rd     = r_ff_rd;
  assign first_fail_actual = r_ff_actual;
`endif

  assign busy         = (r_state == S_RUN) || (r_state == S_CHECK);
  assign done         = (r_state == S_DONE);
  assign pass         = done && (r_fail_count == '0) && !r_timeout;
  assign timeout      = r_timeout;
  assign fail_count   = r_fail_count;
  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;
  assign stall_count  = r_stall_count;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_wb_retire_checker.sv
// Scoreboard bench for wb_retire_checker: a program-level model predicts each run's result,
// a monitor compares it when done rises.
module tb_wb_retire_checker;
  localparam int XLEN = 32, NUM_REGS = 32, NUM_CHECKS = 16, CNT_W = 32, TIMEOUT = 20;
  localparam int RW = $clog2(NUM_REGS), CW = $clog2(NUM_CHECKS);

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic busy, done, pass, timeout;
  logic [CW:0] fail_count;
  logic [CNT_W-1:0] cycle_count, retire_count, stall_count, flush_count;
`ifdef WB_CHECKER_FIRST_FAIL_EN
  logic first_fail_valid;
  logic [RW-1:0] first_fail_rd;
  logic [XLEN-1:0] first_fail_actual;
`endif

  wb_retire_checker_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_CHECKS(NUM_CHECKS)) bus ();

  wb_retire_checker #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .fail_count(fail_count),
    .cycle_count(cycle_count), .retire_count(retire_count),
    .stall_count(stall_count), .flush_count(flush_count)
`ifdef WB_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(first_fail_valid), .first_fail_rd(first_fail_rd),
    .first_fail_actual(first_fail_actual)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we; int rd; int unsigned data; bit stall; bit flush; bit halt;
    bit xwe; int xidx; bit xvalid; int xrd; int unsigned xdata;
  } cyc_t;

  typedef struct {
    int fails; bit pass; bit to; int cycles; int retires; int stalls; int flushes;
    int busy_cycles; bit ff_valid; int ff_rd; int unsigned ff_actual;
  } exp_t;

  int unsigned m_shadow [NUM_REGS];
  bit          m_valid  [NUM_CHECKS];
  int          m_rd     [NUM_CHECKS];
  int unsigned m_data   [NUM_CHECKS];
  exp_t sb_q [$];
  cyc_t prog [$];
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    bus.halt = 1'b0; bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.exp_we = 1'b0; bus.exp_idx = '0; bus.exp_valid = 1'b0; bus.exp_rd = '0; bus.exp_data = '0;
  endtask

  task automatic load_entry(input int idx, input bit v, input int rd, input int unsigned d);
    bus.exp_we = 1'b1; bus.exp_idx = CW'(idx); bus.exp_valid = v;
    bus.exp_rd = RW'(rd); bus.exp_data = d;
    @(negedge clk);
    bus.exp_we = 1'b0;
    m_valid[idx] = v; m_rd[idx] = rd; m_data[idx] = d;
  endtask

  task automatic make_prog(input int n);
    cyc_t c;
    c = '{default: 0};
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(c);
  endtask

  task automatic set_wb(input int k, input int rd, input int unsigned d);
    cyc_t c;
    c = prog[k]; c.we = 1'b1; c.rd = rd; c.data = d; prog[k] = c;
  endtask

  task automatic set_flags(input int k, input bit st, input bit fl, input bit hl);
    cyc_t c;
    c = prog[k]; c.stall = c.stall | st; c.flush = c.flush | fl; c.halt = c.halt | hl; prog[k] = c;
  endtask

  task automatic set_xwe(input int k, input int idx, input int rd, input int unsigned d);
    cyc_t c;
    c = prog[k]; c.xwe = 1'b1; c.xidx = idx; c.xvalid = 1'b1; c.xrd = rd; c.xdata = d; prog[k] = c;
  endtask

  // Plays prog[] as RUN cycles; the model applies the run/scan rules and queues the outcome.
  task automatic run_program(input bit proto);
    exp_t e;
    cyc_t c;
    int k;
    bit fin, seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) m_shadow[r] = 0;
    e = '{default: 0};
    k = 0;
    do begin
      k++;
      if (k <= prog.size()) c = prog[k-1];
      else c = '{default: 0};
      bus.wb_we = c.we; bus.wb_rd = RW'(c.rd); bus.wb_data = c.data;
      bus.stall = c.stall; bus.flush = c.flush; bus.halt = c.halt;
      bus.exp_we = c.xwe; bus.exp_idx = CW'(c.xidx); bus.exp_valid = c.xvalid;
      bus.exp_rd = RW'(c.xrd); bus.exp_data = c.xdata;
      e.cycles = k;
      e.stalls += int'(c.stall);
      e.flushes += int'(c.flush);
      if (c.we && c.rd != 0) begin
        m_shadow[c.rd] = c.data;
        e.retires++;
      end
      e.to = (k == TIMEOUT);
      fin = e.to || c.halt;
      @(negedge clk);
    end while (!fin);
    idle_inputs();
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (m_valid[i] && m_shadow[m_rd[i]] != m_data[i]) begin
        if (e.fails == 0) begin
          e.ff_valid = 1'b1; e.ff_rd = m_rd[i]; e.ff_actual = m_shadow[m_rd[i]];
        end
        e.fails++;
      end
    end
    e.pass = (e.fails == 0) && !e.to;
    e.busy_cycles = k + NUM_CHECKS;
    sb_q.push_back(e);
    if (proto) begin
      start = 1'b1; bus.halt = 1'b1; bus.exp_we = 1'b1;
      bus.exp_idx = CW'($urandom_range(0, NUM_CHECKS - 1)); bus.exp_valid = 1'b1;
      bus.exp_rd = RW'($urandom_range(1, 7)); bus.exp_data = $urandom;
      @(negedge clk);
      idle_inputs();
    end
    seen = 1'b0;
    for (int w = 0; w < NUM_CHECKS + 10 && !seen; w++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_reached", 64'(seen), 64'd1);
    @(negedge clk);
    prog.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_fail_count"}, 64'(fail_count), 64'd0);
    check({tag, "_counters"}, 64'(cycle_count | retire_count | stall_count | flush_count), 64'd0);
  endtask

  // Monitor: counts busy cycles and compares the queued prediction when done rises.
  bit mon_prev_done = 1'b0;
  int mon_busy_cycles = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) mon_busy_cycles = 0;
      else if (busy) mon_busy_cycles++;
      if (done && !mon_prev_done) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=done expected=no pending run (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("fail_count", 64'(fail_count), 64'(e.fails));
          check("pass", 64'(pass), 64'(e.pass));
          check("timeout", 64'(timeout), 64'(e.to));
          check("cycle_count", 64'(cycle_count), 64'(e.cycles));
          check("retire_count", 64'(retire_count), 64'(e.retires));
          check("stall_count", 64'(stall_count), 64'(e.stalls));
          check("flush_count", 64'(flush_count), 64'(e.flushes));
          check("busy_cycles", 64'(mon_busy_cycles), 64'(e.busy_cycles));
          check("busy_in_done", 64'(busy), 64'd0);
`ifdef WB_CHECKER_FIRST_FAIL_EN
          check("first_fail_valid", 64'(first_fail_valid), 64'(e.ff_valid));
          if (e.ff_valid) begin
            check("first_fail_rd", 64'(first_fail_rd), 64'(e.ff_rd));
            check("first_fail_actual", 64'(first_fail_actual), 64'(e.ff_actual));
          end
`endif
        end
        mon_busy_cycles = 0;
      end
      mon_prev_done = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=still running expected=finished (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc_t c;
    int len;
    idle_inputs();
    for (int i = 0; i < NUM_CHECKS; i++) begin m_valid[i] = 0; m_rd[i] = 0; m_data[i] = 0; end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic run: matching registers, write to x0 dropped, halt on cycle 10.
    load_entry(0, 1, 1, 1);
    load_entry(1, 1, 2, 2);
    load_entry(2, 1, 5, 3);
    load_entry(3, 1, 0, 0);
    make_prog(10);
    set_wb(1, 1, 1); set_wb(3, 2, 2); set_wb(5, 5, 3); set_wb(6, 0, 32'h55);
    set_flags(9, 0, 0, 1);
    run_program(0);

    // Mismatch: x6 expected 6, written 5.
    load_entry(0, 0, 0, 0);
    load_entry(1, 0, 0, 0);
    load_entry(2, 0, 0, 0);
    load_entry(3, 1, 6, 6);
    make_prog(5);
    set_wb(1, 6, 5);
    set_flags(4, 0, 0, 1);
    run_program(0);

    // Timeout with an empty table, then halt coinciding with the timeout cycle.
    for (int i = 0; i < NUM_CHECKS; i++) load_entry(i, 0, 0, 0);
    make_prog(0);
    run_program(0);
    make_prog(TIMEOUT);
    set_flags(TIMEOUT - 1, 0, 0, 1);
    run_program(0);

    // Counters: stall 3 cycles, flush 2 cycles, overlapping once.
    make_prog(6);
    set_flags(0, 1, 0, 0); set_flags(1, 1, 0, 0); set_flags(2, 1, 1, 0);
    set_flags(3, 0, 1, 0); set_flags(5, 0, 0, 1);
    run_program(0);

    // Protocol: table writes during RUN, start/halt/table write during CHECK.
    load_entry(0, 1, 7, 7);
    make_prog(4);
    set_wb(0, 7, 7);
    set_xwe(1, 0, 7, 99);
    set_xwe(2, 5, 3, 1);
    set_flags(3, 0, 0, 1);
    run_program(1);

    // Reset mid-run, then a run with no reload must pass.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = RW'(7); bus.wb_data = 32'd7;
    repeat (2) @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_run");
    for (int i = 0; i < NUM_CHECKS; i++) m_valid[i] = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    make_prog(3);
    set_flags(2, 0, 0, 1);
    run_program(0);

    // Randomized programs against the model.
    for (int r = 0; r < 15; r++) begin
      for (int j = 0; j < 3; j++)
        load_entry($urandom_range(0, NUM_CHECKS - 1), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, 3));
      len = $urandom_range(1, TIMEOUT + 4);
      prog.delete();
      for (int k = 0; k < len; k++) begin
        c = '{default: 0};
        c.we = ($urandom_range(0, 1) == 1);
        c.rd = $urandom_range(0, 7);
        c.data = $urandom_range(0, 3);
        c.stall = ($urandom_range(0, 9) < 3);
        c.flush = ($urandom_range(0, 9) < 3);
        c.halt = (k == len - 1);
        if ($urandom_range(0, 9) < 2) begin
          c.xwe = 1'b1; c.xidx = $urandom_range(0, NUM_CHECKS - 1); c.xvalid = 1'b1;
          c.xrd = $urandom_range(0, 7); c.xdata = $urandom;
        end
        prog.push_back(c);
      end
      run_program(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_retire_checker.md
Name: wb_retire_checker

Overview:
- Synthesizable, parametrised writeback checker that attaches to the pipelined CPU's register-file write port.
- Keeps a shadow copy of architectural registers, counts cycles, writebacks, stalls and flushes, and stops on halt or timeout.
- After stopping, it compares the shadow copy against a loadable table of expected register values and reports pass/fail.
- Used by benches and on-FPGA self-test to replace hand-written per-register checks.

Parameters:
- XLEN, 32, datapath/register width.
- NUM_REGS, 32, architectural register count (index width RW = clog2(NUM_REGS)).
- NUM_CHECKS, 16, expected-table entries (index width CW = clog2(NUM_CHECKS)).
- CNT_W, 32, width of all performance counters.
- TIMEOUT, 1000, run-cycle limit before a forced stop.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse: clear state, begin RUN.
- halt  in  1  program-complete indication from CPU/bench.
- wb_we  in  1  register-file write enable (MEM/WB stage).
- wb_rd  in  RW  write address.
- wb_data  in  XLEN  write data.
- stall  in  1  pipeline stall this cycle.
- flush  in  1  pipeline flush this cycle.
- exp_we  in  1  expected-table write strobe.
- exp_idx  in  CW  table entry index.
- exp_valid  in  1  entry valid bit written with the entry.
- exp_rd  in  RW  register to check.
- exp_data  in  XLEN  expected value.
- busy  out  1  high in RUN or CHECK.
- done  out  1  high in DONE.
- pass  out  1  DONE, zero mismatches, no timeout.
- timeout  out  1  run ended by TIMEOUT.
- fail_count  out  CW+1  mismatching valid entries.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retire_count  out  CNT_W  writebacks with wb_rd != 0.
- stall_count  out  CNT_W  RUN cycles with stall=1.
- flush_count  out  CNT_W  RUN cycles with flush=1.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All outputs 0.
  - Shadow registers 0.
  - All table valid bits 0.
- States: IDLE, RUN, CHECK, DONE.
- IDLE / DONE -> RUN on start.
  - Next edge clears counters, fail_count, timeout and the shadow file.
  - The table is preserved.
  - busy=1 the cycle after start.
- RUN, every edge:
  - cycle_count += 1.
  - stall_count += stall.
  - flush_count += flush.
  - If wb_we && wb_rd != 0: shadow[wb_rd] <= wb_data and retire_count += 1.
  - Writes to x0 are dropped; shadow[0] stays 0.
- RUN -> CHECK:
  - On halt=1. The writeback on that same edge is still captured.
  - Or when cycle_count reaches TIMEOUT-1 (the TIMEOUT-th RUN cycle). This sets timeout=1.
  - If halt and timeout coincide, timeout wins (timeout=1).
- CHECK:
  - Scans idx 0..NUM_CHECKS-1, one entry per cycle (exactly NUM_CHECKS cycles).
  - Valid entry with shadow[exp_rd] != exp_data: fail_count += 1.
  - Invalid entries are skipped but still consume a cycle.
  - Writebacks are ignored.
  - After the last entry -> DONE.
- DONE:
  - done=1, busy=0.
  - pass = (fail_count==0) && !timeout.
  - Counters and flags hold until the next start.
- Counters saturate at all-ones; no wrap.
- exp_we is accepted only in IDLE or DONE; ignored in RUN or CHECK.
- start in RUN or CHECK is ignored.
- halt outside RUN is ignored.
- Reset mid-RUN or mid-CHECK: immediate return to IDLE, with the same reset values as above (table invalidated).

Optional Feature:
- Macro: WB_CHECKER_FIRST_FAIL_EN.
- Defined: adds three outputs, all cleared on start/reset, all captured at the first mismatch of a CHECK pass:
  - first_fail_valid (1)
  - first_fail_rd (RW)
  - first_fail_actual (XLEN)
- Undefined: the ports do not exist, and no capture logic is built.

Test Plan:
- Basic run:
  - Stimulus: load entries {x1=1, x2=2, x5=3}; start; drive writebacks x1=1, x2=2, x5=3, x0=0x55; halt on cycle 10.
  - Response: DONE after 10+16 cycles; pass=1; retire_count=3; shadow x0 stays 0; cycle_count=10.
- Mismatch:
  - Stimulus: expect x6=6, write x6=5.
  - Response: fail_count=1, pass=0. With WB_CHECKER_FIRST_FAIL_EN: first_fail_rd=6, first_fail_actual=5.
- Timeout:
  - Stimulus: TIMEOUT=20; start; never assert halt.
  - Response: timeout=1 after cycle_count=20; pass=0 even with an empty table.
- Counters:
  - Stimulus: in RUN, stall on 3 cycles, flush on 2 cycles; flush and stall coincide on 1 of those cycles.
  - Response: stall_count=3, flush_count=2.
- Protocol:
  - Stimulus: exp_we during RUN; start during CHECK.
  - Response: table unchanged; scan completes normally.
- Reset mid-run:
  - Stimulus: reset low during RUN for 1 cycle, then start with no table reload.
  - Response: all outputs 0 immediately; after halt, pass=1 with fail_count=0 (table invalidated).
